mpsk_modulator: RTL

//  Parametrised M-PSK modulator (BPSK/QPSK/8PSK) that supersedes the four-generator QPSK design.

---
 rtl/mpsk_modulator_if.sv | 10 +
 rtl/mpsk_modulator.sv | 97 +++++++++
 2 files changed

// File: rtl/mpsk_modulator_if.sv
// mpsk_modulator_if: valid/ready symbol stream feeding the M-PSK modulator
interface mpsk_modulator_if #(
  parameter int BPS = 2
);
  logic [BPS-1:0] sym_data;
  logic           sym_valid;
  logic           sym_ready;
  modport master (output sym_data, sym_valid, input sym_ready);
  modport slave  (input sym_data, sym_valid, output sym_ready);
endinterface

// File: rtl/mpsk_modulator.sv
// mpsk_modulator: M-PSK modulator, one DDS accumulator plus symbol phase offset into a sine ROM; MPSK_GRAY_EN selects Gray symbol mapping
module mpsk_modulator #(
  parameter int BPS     = 2,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 12,
  parameter int OUT_W   = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic [31:0]             sym_period,
  mpsk_modulator_if.slave         sym,
  output logic signed [OUT_W-1:0] sin_out,
  output logic                    sym_strobe,
  output logic                    underrun
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int  N   = 2**LUT_AW;
  localparam real AMP = real'(2**(OUT_W-1) - 1);
  state_t                  state_q, state_d;
  logic [PHASE_W-1:0]      acc_q, acc_d, ph;
  logic [31:0]             cnt_q, cnt_d, per_q, per_d;
  logic [BPS-1:0]          cur_sym_q, cur_sym_d, map_sym;
  logic [LUT_AW-1:0]       addr_q, addr_d;
  logic signed [OUT_W-1:0] sin_q, sin_d;
  logic                    load_q, load_d, stb1_q, stb1_d, stb2_q, stb2_d;
  logic                    boundary, ready, accept;
  logic signed [OUT_W-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = OUT_W'(int'(AMP * $sin(6.283185307179586 * real'(k) / real'(N))));
  end

  // handshake: take a symbol when idle and enabled, or on the last clock of the current symbol
  always_comb begin
    boundary      = (state_q == RUN) && (cnt_q == per_q - 32'd1);
    ready         = en && ((state_q == IDLE) || boundary);
    accept        = ready && sym.sym_valid;
    sym.sym_ready = reset && ready;
    underrun      = en && boundary && !sym.sym_valid;
  end

  // next state: run while enabled, accumulate carrier phase, count clocks within a symbol
  always_comb begin
    state_d   = (en && ((state_q == RUN) || accept)) ? RUN : IDLE;
    acc_d     = (en && (state_q == RUN)) ? acc_q + phase_inc : '0;
    cnt_d     = (en && (state_q == RUN) && !boundary) ? cnt_q + 32'd1 : '0;
    cur_sym_d = accept ? sym.sym_data : cur_sym_q;
    per_d     = accept ? ((sym_period == 32'd0) ? 32'd1 : sym_period) : per_q;
    load_d    = accept;
    stb1_d    = load_q;
    stb2_d    = stb1_q;
  end

  // datapath: symbol phase added as an offset, registered ROM address, registered ROM output
  always_comb begin
`ifdef MPSK_GRAY_EN
    map_sym = cur_sym_q ^ (cur_sym_q >> 1) ^ (cur_sym_q >> 2);
`else
    map_sym = cur_sym_q;
`endif
    ph     = acc_q + {map_sym, {(PHASE_W-BPS){1'b0}}};
    addr_d = (state_q == RUN) ? LUT_AW'(ph >> (PHASE_W - LUT_AW)) : '0;
    sin_d  = rom[addr_q];
  end

  // state, accumulator and pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      per_q     <= 32'd1;
      cur_sym_q <= '0;
      addr_q    <= '0;
      sin_q     <= '0;
      load_q    <= 1'b0;
      stb1_q    <= 1'b0;
      stb2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      cur_sym_q <= cur_sym_d;
      addr_q    <= addr_d;
      sin_q     <= sin_d;
      load_q    <= load_d;
      stb1_q    <= stb1_d;
      stb2_q    <= stb2_d;
    end
  end

  assign sin_out    = sin_q;
  assign sym_strobe = stb2_q;
endmodule
